npu_axil_ctrl: RTL



---
 rtl/npu_axil_if.sv | 36 +++
 rtl/npu_axil_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/npu_axil_if.sv
// AXI4-Lite channel bundle for the NPU control block.
// The slave modport is the register block's side; the master modport is the CPU/bench side.
interface npu_axil_if #(
  parameter int DW = 32,
  parameter int AW = 6
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid, awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid, wready;
  logic [1:0]      bresp;
  logic            bvalid, bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid, arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid, rready;

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );
  modport master (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );
endinterface

// File: rtl/npu_axil_ctrl.sv
// AXI4-Lite register block for the MNIST NPU: weight/bias streaming, layer/neuron
// select, soft reset, a result FIFO drained through the OUT register, and a level irq.
module npu_axil_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int OUT_FIFO_DEPTH     = 16
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  npu_axil_if.slave                     s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] layerNumber,
  output logic [C_S_AXI_DATA_WIDTH-1:0] neuronNumber,
  output logic [C_S_AXI_DATA_WIDTH-1:0] weightValue,
  output logic [C_S_AXI_DATA_WIDTH-1:0] biasValue,
  output logic                          weightValid,
  output logic                          biasValid,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] nnOut,
  input  logic                          nnOut_valid,
  output logic                          axi_rd_en,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] axi_rd_data,
  output logic                          softReset,
  output logic                          irq
);
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam int PW = $clog2(OUT_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(OUT_FIFO_DEPTH);

  logic          rst_done;
  logic          aw_full, w_full, bvalid_q, rvalid_q, rd_is_rddata;
  logic [IW-1:0] aw_idx_q, rd_idx;
  logic [31:0]   wdata_q, rdata_q, rd_data_c, status;
  logic [3:0]    wstrb_q;
  logic [1:0]    bresp_q, rresp_q, rd_resp_c, ctrl_q;
  logic          aw_hs, w_hs, ar_hs, commit, wr_ok, clr_ovf;
  logic [31:0]   mem [OUT_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic          ovf, push, pop, do_push, not_empty;
  logic          unused;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  // READY is held low until the first clock after reset release.
  assign s_axi.awready = rst_done && !aw_full && !bvalid_q;
  assign s_axi.wready  = rst_done && !w_full  && !bvalid_q;
  assign s_axi.arready = rst_done && !rvalid_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

  assign aw_hs   = s_axi.awvalid && s_axi.awready;
  assign w_hs    = s_axi.wvalid  && s_axi.wready;
  assign ar_hs   = s_axi.arvalid && s_axi.arready;
  assign commit  = aw_full && w_full;
  assign rd_idx  = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign clr_ovf = commit && wr_ok && (int'(aw_idx_q) == 8) && wdata_q[2];
  assign unused  = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  assign softReset = ctrl_q[0];
  assign not_empty = (fifo_cnt != '0);
  assign irq       = ctrl_q[1] && (not_empty || ovf);

  always_comb begin
    case (int'(aw_idx_q))
      0, 1, 3, 4, 7, 8: wr_ok = 1'b1;
      default:          wr_ok = 1'b0;
    endcase
  end

  always_comb begin
    status        = '0;
    status[0]     = not_empty;
    status[1]     = (fifo_cnt == FULL_CNT);
    status[2]     = ovf;
    status[15:8]  = 8'(fifo_cnt);
  end

  // Write-only and unmapped indices fall through to SLVERR with zero data.
  always_comb begin
    rd_data_c = '0;
    rd_resp_c = 2'b00;
    case (int'(rd_idx))
      2: if (not_empty) rd_data_c = mem[rd_ptr]; else rd_resp_c = 2'b10;
      3: rd_data_c = layerNumber;
      4: rd_data_c = neuronNumber;
      5: rd_data_c = axi_rd_data;
      6: rd_data_c = status;
      7: rd_data_c = {30'd0, ctrl_q};
      default: rd_resp_c = 2'b10;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rst_done <= 1'b0;
      aw_full <= 1'b0; w_full <= 1'b0; aw_idx_q <= '0; wdata_q <= '0; wstrb_q <= '0;
      bvalid_q <= 1'b0; bresp_q <= 2'b00;
      weightValue <= '0; biasValue <= '0; layerNumber <= '0; neuronNumber <= '0;
      weightValid <= 1'b0; biasValid <= 1'b0; ctrl_q <= 2'b00;
    end else begin
      rst_done    <= 1'b1;
      weightValid <= 1'b0;
      biasValid   <= 1'b0;
      if (aw_hs) begin aw_full <= 1'b1; aw_idx_q <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2]; end
      if (w_hs)  begin w_full <= 1'b1; wdata_q <= s_axi.wdata; wstrb_q <= s_axi.wstrb; end
      if (commit) begin
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? 2'b00 : 2'b10;
        case (int'(aw_idx_q))
          0: begin weightValue <= merge(weightValue, wdata_q, wstrb_q); weightValid <= 1'b1; end
          1: begin biasValue   <= merge(biasValue,   wdata_q, wstrb_q); biasValid   <= 1'b1; end
          3: layerNumber  <= merge(layerNumber,  wdata_q, wstrb_q);
          4: neuronNumber <= merge(neuronNumber, wdata_q, wstrb_q);
          7: if (wstrb_q[0]) ctrl_q <= wdata_q[1:0];
          default: ;
        endcase
      end else if (bvalid_q && s_axi.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rvalid_q <= 1'b0; rdata_q <= '0; rresp_q <= 2'b00;
      rd_is_rddata <= 1'b0; axi_rd_en <= 1'b0;
    end else begin
      axi_rd_en <= rvalid_q && s_axi.rready && rd_is_rddata;
      if (ar_hs) begin
        rvalid_q     <= 1'b1;
        rdata_q      <= rd_data_c;
        rresp_q      <= rd_resp_c;
        rd_is_rddata <= (int'(rd_idx) == 5);
      end else if (rvalid_q && s_axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // A same-cycle pop frees the full slot, so the push is still accepted.
  assign push    = nnOut_valid && !softReset;
  assign pop     = ar_hs && (int'(rd_idx) == 2) && not_empty;
  assign do_push = push && ((fifo_cnt != FULL_CNT) || pop);

  always_ff @(posedge S_AXI_ACLK) begin
    if (do_push) mem[wr_ptr] <= nnOut;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_ptr <= '0; rd_ptr <= '0; fifo_cnt <= '0; ovf <= 1'b0;
    end else begin
      if (push && !do_push) ovf <= 1'b1;
      else if (clr_ovf)     ovf <= 1'b0;
      if (softReset) begin
        wr_ptr <= '0; rd_ptr <= '0; fifo_cnt <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        fifo_cnt <= fifo_cnt + CW'(do_push) - CW'(pop);
      end
    end
  end
endmodule
